// File: rtl/adder_stim_pkg.sv
// Shared definitions for the adder operand generator.
//   LFSR_W / LFSR_MASK : width and Galois feedback mask of the operand LFSR
//   BIAS_THRESH        : low-nibble threshold giving a 6/16 chance of a 1
//   LFSR_STEPS         : LFSR advances per generated bit
//   state_t            : generator FSM states
//   lfsr_step()        : one right-shifting Galois step
package adder_stim_pkg;

  localparam int                LFSR_W      = 16;
  localparam logic [LFSR_W-1:0] LFSR_MASK   = 16'hB400;
  localparam logic [3:0]        BIAS_THRESH = 4'd10;
  localparam int                LFSR_STEPS  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l);
    logic [LFSR_W-1:0] r;
    r = l >> 1;
    if (l[0]) begin
      r = r ^ LFSR_MASK;
    end
    return r;
  endfunction

endpackage

// File: rtl/biased_bit_lfsr.sv
// Biased random bit source.
// A 16-bit Galois LFSR whose low nibble is compared against a threshold,
// giving a 1 with probability 6/16. The bit reflects the current LFSR value;
// when enabled the LFSR moves on by four steps so successive bits come from
// (mostly) fresh nibbles.
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset, loads the seed
//   load_seed : synchronous reload of the seed
//   en        : consume the current bit and advance the LFSR
//   rnd_bit   : biased random bit
module biased_bit_lfsr
  import adder_stim_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic clk,
  input  logic rst,
  input  logic load_seed,
  input  logic en,
  output logic rnd_bit
);

  // The all-zero state is a lock-up state for the LFSR, so a zero seed is
  // replaced by 1.
  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? LFSR_W'(1) : SEED;

  logic [LFSR_W-1:0] lfsr_reg;
  logic [LFSR_W-1:0] lfsr_next;

  always_comb begin
    lfsr_next = lfsr_reg;
    for (int i = 0; i < LFSR_STEPS; i++) begin
      lfsr_next = lfsr_step(lfsr_next);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_reg <= SEED_EFF;
    end else if (load_seed) begin
      lfsr_reg <= SEED_EFF;
    end else if (en) begin
      lfsr_reg <= lfsr_next;
    end
  end

  assign rnd_bit = (lfsr_reg[3:0] >= BIAS_THRESH);

endmodule

// File: rtl/adder_operand_gen.sv
// Operand source for the ripple-carry adder under test.
// A run of num_vectors vectors is started in IDLE. Each vector takes 2N+1
// biased random bits, shifted in MSB-first into a staging register, and is
// then moved into the output slot {a, b, cin} and offered with valid/ready.
// Staging of the next vector continues while the slot is occupied.
// Ports:
//   clk, rst    : clock and asynchronous active-high reset
//   start       : begin a run (only looked at in IDLE)
//   num_vectors : vector count for the run, captured with start
//   ready       : downstream accepts the vector on offer
//   valid       : a / b / cin hold a vector
//   a, b, cin   : operands and carry-in
//   busy        : a run is in progress
//   done        : single-cycle pulse after the last vector is accepted
module adder_operand_gen
  import adder_stim_pkg::*;
#(
  parameter int                N     = 8,
  parameter int                CNT_W = 16,
  parameter logic [LFSR_W-1:0] SEED  = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vectors,
  input  logic             ready,
  output logic             valid,
  output logic [N-1:0]     a,
  output logic [N-1:0]     b,
  output logic             cin,
  output logic             busy,
  output logic             done
);

  localparam int              SH_W    = 2 * N + 1;
  localparam int              BC_W    = $clog2(SH_W + 1);
  localparam logic [BC_W-1:0] BC_FULL = BC_W'(SH_W);

  state_t             state_reg;
  state_t             state_next;
  logic [SH_W-1:0]    sh_reg;
  logic [BC_W-1:0]    bc_reg;
  logic [CNT_W-1:0]   loaded_reg;
  logic [CNT_W-1:0]   accepted_reg;
  logic [CNT_W-1:0]   num_reg;
  logic               valid_reg;
  logic [N-1:0]       a_reg;
  logic [N-1:0]       b_reg;
  logic               cin_reg;
  logic               busy_reg;
  logic               done_reg;

  logic seed_load;
  logic gen_en;
  logic load_en;
  logic accept;
  logic last_accept;
  logic rnd_bit;

  // Staging stops once every vector of the run has been moved into the slot,
  // and also when a fully staged vector is waiting for the slot to free up.
  assign seed_load   = (state_reg == IDLE) && start;
  assign gen_en      = (state_reg == RUN) && (bc_reg < BC_FULL) && (loaded_reg < num_reg);
  assign load_en     = (state_reg == RUN) && (bc_reg == BC_FULL) && (!valid_reg || ready);
  assign accept      = (state_reg == RUN) && valid_reg && ready;
  assign last_accept = accept && ((accepted_reg + CNT_W'(1)) == num_reg);

  biased_bit_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clk       (clk),
    .rst       (rst),
    .load_seed (seed_load),
    .en        (gen_en),
    .rnd_bit   (rnd_bit)
  );

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = (num_vectors == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_accept) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      sh_reg       <= '0;
      bc_reg       <= '0;
      loaded_reg   <= '0;
      accepted_reg <= '0;
      num_reg      <= '0;
      valid_reg    <= 1'b0;
      a_reg        <= '0;
      b_reg        <= '0;
      cin_reg      <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= (state_next == RUN);
      done_reg  <= (state_next == DONE);

      if (seed_load) begin
        bc_reg       <= '0;
        loaded_reg   <= '0;
        accepted_reg <= '0;
        num_reg      <= num_vectors;
      end else begin
        // gen_en and load_en are exclusive: they need bc below / at full.
        if (gen_en) begin
          sh_reg <= {sh_reg[SH_W-2:0], rnd_bit};
          bc_reg <= bc_reg + BC_W'(1);
        end
        if (load_en) begin
          a_reg      <= sh_reg[2*N:N+1];
          b_reg      <= sh_reg[N:1];
          cin_reg    <= sh_reg[0];
          bc_reg     <= '0;
          loaded_reg <= loaded_reg + CNT_W'(1);
        end
        if (accept) begin
          accepted_reg <= accepted_reg + CNT_W'(1);
        end
        // A load in the accept cycle refills the slot immediately.
        if (load_en) begin
          valid_reg <= 1'b1;
        end else if (accept) begin
          valid_reg <= 1'b0;
        end
      end
    end
  end

  assign valid = valid_reg;
  assign a     = a_reg;
  assign b     = b_reg;
  assign cin   = cin_reg;
  assign busy  = busy_reg;
  assign done  = done_reg;

endmodule

// File: tb/tb_adder_operand_gen.sv
module tb_adder_operand_gen;

  localparam int N      = 8;
  localparam int CNT_W  = 16;
  localparam int NV_MAX = 2000;
  localparam int VBITS  = 2 * N + 1;

  logic             clk;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] num_vectors;
  logic             ready;
  logic             valid;
  logic [N-1:0]     a;
  logic [N-1:0]     b;
  logic             cin;
  logic             busy;
  logic             done;

  adder_operand_gen #(
    .N     (N),
    .CNT_W (CNT_W),
    .SEED  (16'hACE1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_vectors (num_vectors),
    .ready       (ready),
    .valid       (valid),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned check_cnt = 0;
  int unsigned error_cnt = 0;

  // Golden vector sequence built straight from the bit-stream rules.
  logic [N-1:0] ga [NV_MAX];
  logic [N-1:0] gb [NV_MAX];
  logic         gc [NV_MAX];
  int unsigned  model_ones = 0;

  // Monitor state
  int unsigned  exp_idx   = 0;
  int unsigned  hs_total  = 0;
  int unsigned  ones_cnt  = 0;
  logic         hold_pend = 1'b0;
  logic [N-1:0] hold_a, hold_b;
  logic         hold_c;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got !== exp) begin
      error_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Observe outputs at the current falling edge together with the inputs
  // that the next rising edge will sample, then advance one cycle.
  task automatic tick();
    if (rst || !busy) begin
      exp_idx   = 0;
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check_val("hold", 32'({valid, a, b, cin}), 32'({1'b1, hold_a, hold_b, hold_c}));
      end
      if (valid && ready) begin
        if (exp_idx < NV_MAX) begin
          check_val("vec_a", 32'(a), 32'(ga[exp_idx]));
          check_val("vec_b", 32'(b), 32'(gb[exp_idx]));
          check_val("vec_cin", 32'(cin), 32'(gc[exp_idx]));
          $display("vec %0d: a=%02h b=%02h cin=%0d", exp_idx, a, b, cin);
        end
        ones_cnt += 32'($countones({a, b, cin}));
        exp_idx++;
        hs_total++;
        hold_pend = 1'b0;
      end else if (valid) begin
        hold_pend = 1'b1;
        hold_a    = a;
        hold_b    = b;
        hold_c    = cin;
      end else begin
        hold_pend = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_start(input int unsigned n);
    start       = 1'b1;
    num_vectors = CNT_W'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    check_val(tag, 32'(done), 32'd1);
    tick();
  endtask

  initial begin
    int unsigned l;
    int unsigned vec;
    l = 32'hACE1;
    for (int v = 0; v < NV_MAX; v++) begin
      vec = 0;
      for (int k = 0; k < VBITS; k++) begin
        vec = (vec << 1) | (((l & 32'hF) >= 10) ? 32'd1 : 32'd0);
        for (int s = 0; s < 4; s++) begin
          l = ((l & 32'd1) != 0) ? ((l >> 1) ^ 32'hB400) : (l >> 1);
        end
      end
      ga[v] = N'(vec >> (N + 1));
      gb[v] = N'(vec >> 1);
      gc[v] = vec[0];
      model_ones += 32'($countones(vec));
    end
  end

  initial begin
    int t;
    int valid_cnt;
    int done_t;
    int done_cnt;
    int hs0;
    int ones0;
    int n;
    logic busy90, busy91;
    logic ok;

    rst = 1'b1; start = 1'b0; num_vectors = '0; ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("rst_valid", 32'(valid), 32'd0);
    check_val("rst_ab", 32'({a, b, cin}), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    tick();

    // Run of 5 with ready held high: timing of valid, done and busy.
    ready = 1'b1;
    hs0 = hs_total;
    do_start(5);
    valid_cnt = 0; done_t = -1; done_cnt = 0; busy90 = 1'b0; busy91 = 1'b1;
    for (t = 0; t <= 110; t++) begin
      if (valid) begin
        valid_cnt++;
        check_val("valid_time", 32'(t), 32'(18 * valid_cnt));
      end
      if (done) begin
        done_cnt++;
        done_t = t;
      end
      if (t == 90) busy90 = busy;
      if (t == 91) busy91 = busy;
      tick();
    end
    check_val("valid_cnt", 32'(valid_cnt), 32'd5);
    check_val("done_time", 32'(done_t), 32'd91);
    check_val("done_cnt", 32'(done_cnt), 32'd1);
    check_val("busy_e90", 32'(busy90), 32'd1);
    check_val("busy_e91", 32'(busy91), 32'd0);
    check_val("hs_5", hs_total - hs0, 32'd5);
    check_val("idle_busy", 32'(busy), 32'd0);

    // Zero-length run.
    do_start(0);
    check_val("zero_done0", 32'(done), 32'd1);
    check_val("zero_busy0", 32'(busy), 32'd0);
    check_val("zero_valid0", 32'(valid), 32'd0);
    tick();
    check_val("zero_done1", 32'(done), 32'd0);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (valid || busy) ok = 1'b1;
      tick();
    end
    check_val("zero_quiet", 32'(ok), 32'd0);

    // Backpressure: first vector held for 100 cycles.
    ready = 1'b0;
    hs0 = hs_total;
    do_start(3);
    t = 0;
    while (!valid && t < 40) begin
      tick();
      t++;
    end
    check_val("bp_first_t", 32'(t), 32'd18);
    check_val("bp_first_a", 32'(a), 32'(ga[0]));
    check_val("bp_first_b", 32'(b), 32'(gb[0]));
    check_val("bp_first_c", 32'(cin), 32'(gc[0]));
    for (int i = 0; i < 100; i++) tick();
    ready = 1'b1;
    tick();
    check_val("bp_next_valid", 32'(valid), 32'd1);
    check_val("bp_next_vec", 32'({a, b, cin}), 32'({ga[1], gb[1], gc[1]}));
    wait_done(200, "bp_done");
    check_val("bp_hs", hs_total - hs0, 32'd3);

    // Reset while vector 3 of 10 is on offer, then a fresh identical run.
    ready = 1'b1;
    hs0 = hs_total;
    do_start(10);
    valid_cnt = 0;
    t = 0;
    while (valid_cnt < 3 && t < 200) begin
      if (valid) valid_cnt++;
      if (valid_cnt < 3) begin
        tick();
        t++;
      end
    end
    check_val("mid_reached", 32'(valid_cnt), 32'd3);
    #2 rst = 1'b1;
    #1;
    check_val("mid_valid", 32'(valid), 32'd0);
    check_val("mid_abc", 32'({a, b, cin}), 32'd0);
    check_val("mid_busy", 32'(busy), 32'd0);
    check_val("mid_hs", hs_total - hs0, 32'd2);
    tick();
    rst = 1'b0;
    tick();
    hs0 = hs_total;
    do_start(10);
    for (int i = 0; i < 30; i++) tick();
    start = 1'b1;
    num_vectors = CNT_W'(3);
    tick();
    start = 1'b0;
    check_val("start_ignored_busy", 32'(busy), 32'd1);
    wait_done(400, "restart_done");
    check_val("restart_hs", hs_total - hs0, 32'd10);

    // Long run with random ready: content, count and bias.
    hs0 = hs_total;
    ones0 = ones_cnt;
    do_start(NV_MAX);
    n = 0;
    while (!done && n < 60000) begin
      ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    check_val("long_done", 32'(done), 32'd1);
    tick();
    check_val("long_hs", hs_total - hs0, 32'(NV_MAX));
    check_val("long_ones", ones_cnt - ones0, model_ones);
    ok = ((ones_cnt - ones0) * 1000 >= 355 * NV_MAX * VBITS) &&
         ((ones_cnt - ones0) * 1000 <= 395 * NV_MAX * VBITS);
    check_val("long_bias", 32'(ok), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
    $finish;
  end

endmodule
